lsfr_rng_arbiter: RTL and testbench

- Owns one LSFR random-number instance and shares its output stream among N_REQ consumers (e.g. selection, crossover, mutation units of the EC engine).
- Sequences LSFR seeding and warm-up, then arbitrates round-robin so each granted consumer receives a distinct LSFR sample.
- Sits between the top-level seed source and the LSFR; consumers slice rnd_o to the width they need.

---
 rtl/lsfr_rng_arbiter.sv | 108 ++++++++++
 tb/tb_lsfr_rng_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsfr_rng_arbiter.sv
// lsfr_rng_arbiter: seeds and warms one LSFR, then shares its samples round-robin; RNG_ZERO_LOCK_RECOVER_EN adds lock recovery
module lsfr_rng_arbiter #(
  parameter int S_WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int WARMUP = 2,
  parameter logic [S_WIDTH-1:0] ZERO_SUB_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_WIDTH-1:0] seed_i,
  input  logic               seed_valid_i,
  input  logic [N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [S_WIDTH-1:0] rnd_o,
  output logic               rnd_valid_o,
  output logic               ready_o,
  output logic [S_WIDTH-1:0] lfsr_seed_o,
  output logic               lfsr_in_valid_o,
  input  logic [S_WIDTH-1:0] lfsr_num_i
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, WARM, SERVE} state_t;
  state_t state;
  logic [S_WIDTH-1:0] seed_q, new_seed;
  logic [PW-1:0] rr_ptr, pick, idx;
  logic [3:0] warm_cnt;
  logic [N_REQ-1:0] elig;
  logic hit, lock, reseed;
`ifdef RNG_ZERO_LOCK_RECOVER_EN
  logic lock_seen;
  assign lock = (state == SERVE) && (lfsr_num_i == '0);
`else
  assign lock = 1'b0;
`endif
  assign reseed = seed_valid_i || lock;
  assign elig = req_i & ~gnt_o;
  // Next seed: external strobe wins over lock recovery; a zero seed would lock the LSFR, so substitute
  always_comb begin
    new_seed = seed_valid_i ? seed_i : seed_q ^ ZERO_SUB_SEED;
    new_seed = (new_seed == '0) ? ZERO_SUB_SEED : new_seed;
  end
  // Round-robin pick: scan downward in offset so the smallest offset from rr_ptr is the one kept
  always_comb begin
    pick = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % N_REQ);
      if (elig[idx]) begin
        pick = idx;
        hit = 1'b1;
      end
    end
  end
  // Sequencer and arbiter; every output is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      seed_q <= '0;
      rr_ptr <= '0;
      warm_cnt <= '0;
      gnt_o <= '0;
      rnd_o <= '0;
      rnd_valid_o <= 1'b0;
      ready_o <= 1'b0;
      lfsr_seed_o <= '0;
      lfsr_in_valid_o <= 1'b0;
`ifdef RNG_ZERO_LOCK_RECOVER_EN
      lock_seen <= 1'b0;
`endif
    end else begin
      lfsr_in_valid_o <= 1'b0;
      gnt_o <= '0;
      rnd_valid_o <= 1'b0;
      if (reseed) begin
        seed_q <= new_seed;
        lfsr_seed_o <= new_seed;
        lfsr_in_valid_o <= 1'b1;
        ready_o <= 1'b0;
        state <= LOAD;
`ifdef RNG_ZERO_LOCK_RECOVER_EN
        if (!seed_valid_i) lock_seen <= 1'b1;
`endif
      end else begin
        case (state)
          LOAD: begin
            state <= WARM;
            warm_cnt <= '0;
          end
          WARM: begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == 4'(WARMUP - 1)) begin
              state <= SERVE;
              ready_o <= 1'b1;
            end
          end
          SERVE: if (hit) begin
            gnt_o <= N_REQ'(1) << pick;
            rnd_valid_o <= 1'b1;
            rnd_o <= lfsr_num_i;
            rr_ptr <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lsfr_rng_arbiter.sv
// tb_lsfr_rng_arbiter: directed table-driven bench for lsfr_rng_arbiter
module tb_lsfr_rng_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] seed = '0;
  logic seed_valid = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rnd;
  logic rnd_valid;
  logic ready;
  logic [7:0] lfsr_seed;
  logic lfsr_in_valid;
  logic [7:0] num = '0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] num;
    logic [3:0] gnt;
    logic       vld;
    logic [7:0] rnd;
  } vec_t;
  vec_t tbl [14];

  lsfr_rng_arbiter dut (
    .clk(clk), .rst_n(rst_n), .seed_i(seed), .seed_valid_i(seed_valid),
    .req_i(req), .gnt_o(gnt), .rnd_o(rnd), .rnd_valid_o(rnd_valid),
    .ready_o(ready), .lfsr_seed_o(lfsr_seed), .lfsr_in_valid_o(lfsr_in_valid),
    .lfsr_num_i(num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 0);
    chk({tag, " rnd"}, 32'(rnd), 0);
    chk({tag, " rnd_valid"}, 32'(rnd_valid), 0);
    chk({tag, " ready"}, 32'(ready), 0);
    chk({tag, " lfsr_seed"}, 32'(lfsr_seed), 0);
    chk({tag, " lfsr_in_valid"}, 32'(lfsr_in_valid), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready timeout"}, 32'(ready), 1);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 8'h11, 4'b0001, 1'b1, 8'h11};
    tbl[1]  = '{4'b1110, 8'h22, 4'b0010, 1'b1, 8'h22};
    tbl[2]  = '{4'b1100, 8'h33, 4'b0100, 1'b1, 8'h33};
    tbl[3]  = '{4'b1000, 8'h44, 4'b1000, 1'b1, 8'h44};
    tbl[4]  = '{4'b0000, 8'h55, 4'b0000, 1'b0, 8'h44};
    tbl[5]  = '{4'b0001, 8'h01, 4'b0001, 1'b1, 8'h01};
    tbl[6]  = '{4'b0001, 8'h02, 4'b0000, 1'b0, 8'h01};
    tbl[7]  = '{4'b0001, 8'h03, 4'b0001, 1'b1, 8'h03};
    tbl[8]  = '{4'b0001, 8'h04, 4'b0000, 1'b0, 8'h03};
    tbl[9]  = '{4'b1001, 8'h05, 4'b1000, 1'b1, 8'h05};
    tbl[10] = '{4'b0001, 8'h06, 4'b0001, 1'b1, 8'h06};
    tbl[11] = '{4'b0110, 8'h07, 4'b0010, 1'b1, 8'h07};
    tbl[12] = '{4'b0100, 8'h08, 4'b0100, 1'b1, 8'h08};
    tbl[13] = '{4'b0000, 8'h09, 4'b0000, 1'b0, 8'h08};

    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    chk("idle ignores req gnt", 32'(gnt), 0);
    chk("idle ready", 32'(ready), 0);
    req = '0;
    seed = 8'd127;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("load in_valid", 32'(lfsr_in_valid), 1);
    chk("load seed 127", 32'(lfsr_seed), 127);
    chk("load ready", 32'(ready), 0);
    @(negedge clk);
    chk("warm1 in_valid", 32'(lfsr_in_valid), 0);
    chk("warm1 ready", 32'(ready), 0);
    @(negedge clk);
    chk("warm2 ready", 32'(ready), 0);
    chk("warm2 gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("serve ready 3 after load", 32'(ready), 1);

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      num = tbl[i].num;
      @(negedge clk);
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d vld", i), 32'(rnd_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d rnd", i), 32'(rnd), 32'(tbl[i].rnd));
      chk($sformatf("row%0d ready", i), 32'(ready), 1);
    end

    seed = 8'd87;
    seed_valid = 1'b1;
    req = 4'b0010;
    num = 8'h6D;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("reseed no gnt", 32'(gnt), 0);
    chk("reseed in_valid", 32'(lfsr_in_valid), 1);
    chk("reseed seed 87", 32'(lfsr_seed), 87);
    chk("reseed ready drop", 32'(ready), 0);
    repeat (2) @(negedge clk);
    chk("reseed warm gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("reseed serve ready", 32'(ready), 1);
    chk("reseed serve gnt pending", 32'(gnt), 0);
    @(negedge clk);
    chk("reseed late gnt", 32'(gnt), 32'b0010);
    chk("reseed late rnd", 32'(rnd), 32'h6D);
    req = '0;

    seed = 8'd0;
    seed_valid = 1'b1;
    @(negedge clk);
    chk("zero seed sub", 32'(lfsr_seed), 32'hA5);
    chk("zero seed in_valid", 32'(lfsr_in_valid), 1);
    seed = 8'd78;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("warm reseed in_valid", 32'(lfsr_in_valid), 1);
    chk("warm reseed seed 78", 32'(lfsr_seed), 78);
    wait_ready("after 78");

    req = 4'b0001;
    num = 8'h00;
    @(negedge clk);
`ifdef RNG_ZERO_LOCK_RECOVER_EN
    chk("lock no gnt", 32'(gnt), 0);
    chk("lock in_valid", 32'(lfsr_in_valid), 1);
    chk("lock seed EB", 32'(lfsr_seed), 32'hEB);
    req = '0;
    num = 8'h5A;
    wait_ready("after lock");
`else
    chk("zero sample gnt", 32'(gnt), 32'b0001);
    chk("zero sample rnd", 32'(rnd), 0);
    chk("zero sample vld", 32'(rnd_valid), 1);
    req = '0;
`endif

    req = 4'b0100;
    num = 8'h3C;
    @(negedge clk);
    req = '0;
    chk("pre-rst gnt", 32'(gnt), 32'b0100);
    rst_n = 1'b0;
    #1 chk_zero("rst during gnt");
    @(negedge clk) rst_n = 1'b1;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("post-rst req ignored", 32'(gnt), 0);
    chk("post-rst ready", 32'(ready), 0);
    req = '0;

    seed = 8'd5;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst during warm");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle after warm rst", 32'(ready), 0);
    chk("idle after warm rst in_valid", 32'(lfsr_in_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
